board_mem_arbiter: RTL and testbench
====================================

// Module: board_mem_arbiter
// PURPOSE
// - Shares one single-port board-state RAM (1 bit per cell) among three requesters: the VGA display
//   reader, the life update engine, and the init/pattern loader (randomize, copy, host writes).
// - Display has absolute priority. Engine and loader share the remaining cycles round-robin.
// - Sits between the requesters and the board RAM macro, replacing per-action direct array access.
// PARAMETERS
// - AW      12  RAM address width (64x64 board = 4096 cells)
// - CNT_W   16  stall-counter width (ARB_PERF_CNT_EN builds only)
// PORTS
// - clk            in   1   system clock (pixel clock domain)
// - reset          in   1   synchronous, active-high reset
// - disp_req       in   1   display read request (active video only)
// - disp_addr      in   AW  display cell index
// - disp_rvalid    out  1   disp_rdata valid (one cycle after disp grant)
// - eng_req        in   1   engine request
// - eng_we         in   1   engine write enable
// - eng_addr       in   AW  engine cell index
// - eng_wdata      in   1   engine write data
// - eng_lock       in   1   engine holds arbitration against loader while asserted and granted
// - eng_gnt        out  1   engine access accepted this cycle
// - eng_rvalid     out  1   rdata valid for engine read (one cycle after grant with eng_we=0)
// - ld_req/ld_we/ld_addr/ld_wdata  in 1/1/AW/1  loader request bundle, same semantics as engine
// - ld_gnt         out  1   loader access accepted this cycle
// - ld_rvalid      out  1   rdata valid for loader read
// - rdata          out  1   shared read data, qualified by the *_rvalid strobes
// - mem_en/mem_we/mem_addr/mem_wdata out 1/1/AW/1  RAM port (sync read, 1-cycle latency)
// - mem_rdata      in   1   RAM read data
// - stall_eng/stall_ld out CNT_W  saturating stall counters (ARB_PERF_CNT_EN only)
// BEHAVIOUR
// - Grants combinational in the request cycle; mem_* driven combinationally from the winner.
// - Priority: disp_req wins unconditionally; disp has no grant output (it must never be refused).
// - Otherwise, if both eng and ld request: lock rule first, then round-robin pointer rr.
// - rr (1 bit) flips to the other requester after each eng/ld grant; reset value rr=0 (engine first).
// - Lock: lock_q set when eng_gnt && eng_lock; cleared when eng_lock=0. While lock_q=1, ld never
//   wins; eng wins whenever disp idle. Display still preempts a locked engine (no grant that cycle).
// - Exactly one of {disp win, eng_gnt, ld_gnt} or none per cycle; mem_en=1 iff a winner exists.
// - No winner: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
// - A requester keeps req/addr/we/wdata stable until its gnt; dropping req before gnt is legal.
// - Read return: owner register (2 bits: none/disp/eng/ld) captures winner when mem_we=0;
//   next cycle exactly one *_rvalid=1 and rdata=mem_rdata. Writes produce no rvalid.
// - Read and write to same address on back-to-back cycles: RAM ordering holds (read sees old data
//   if issued first, new data if issued after the write grant).
// - Reset: eng_gnt=ld_gnt=0 and all *_rvalid=0 during reset; owner=none, rr=0, lock_q=0;
//   an in-flight read at reset assertion produces no rvalid afterwards.
// - Starvation bound: with disp idle, a continuously requesting unlocked engine or loader is granted
//   within 2 cycles.
// CONFIGURATION
// - ARB_PERF_CNT_EN defined: stall_eng/stall_ld count cycles with req=1 && gnt=0; saturate at
//   all-ones; cleared by reset only.
// - ARB_PERF_CNT_EN undefined: stall_* ports and counters absent; all other behaviour identical.
// TESTING
// - Reset held 3 cycles with all reqs=1 -> eng_gnt=ld_gnt=0, all rvalid=0, mem_en=0.
// - eng read addr 0x041 alone (RAM[0x041]=1) -> eng_gnt same cycle, eng_rvalid=1, rdata=1 next cycle.
// - eng and ld both request continuously, disp idle -> grants alternate eng,ld,eng,ld from reset.
// - disp_req=1 with eng_req=1 for 5 cycles -> eng_gnt=0 for 5 cycles, disp_rvalid each following
//   cycle; eng granted first cycle disp_req drops.
// - eng_lock=1 with ld_req=1 for 10 cycles -> ld_gnt=0 throughout; ld granted the cycle after
//   eng_lock drops if eng_req=0.
// - ARB_PERF_CNT_EN: ld blocked 7 cycles -> stall_ld=7; force 2^CNT_W+3 stalls -> stays 0xFFFF.

Source files
------------

// File: rtl/board_mem_arbiter.sv
// Arbiter for the 1-bit-per-cell board RAM: display has absolute priority, engine and loader share
// the rest round-robin with an engine lock. Define ARB_PERF_CNT_EN to add saturating stall counters.
module board_mem_arbiter #(
    parameter int AW    = 12,
    parameter int CNT_W = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    output logic          disp_rvalid_o,
    input  logic          eng_req_i,
    input  logic          eng_we_i,
    input  logic [AW-1:0] eng_addr_i,
    input  logic          eng_wdata_i,
    input  logic          eng_lock_i,
    output logic          eng_gnt_o,
    output logic          eng_rvalid_o,
    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic          ld_wdata_i,
    output logic          ld_gnt_o,
    output logic          ld_rvalid_o,
    output logic          rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_wdata_o,
    input  logic          mem_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_eng_o,
    output logic [CNT_W-1:0] stall_ld_o
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_ENG  = 2'd2,
        OWN_LD   = 2'd3
    } owner_e;

    owner_e owner_q, owner_d;
    logic   rr_q, rr_d;
    logic   lock_q, lock_d;
    logic   disp_win_s, eng_gnt_s, ld_gnt_s;

    // Winner selection; nothing is granted while reset is held.
    always_comb begin
        disp_win_s = 1'b0;
        eng_gnt_s  = 1'b0;
        ld_gnt_s   = 1'b0;
        if (reset_i) begin
            disp_win_s = 1'b0;
        end else if (disp_req_i) begin
            disp_win_s = 1'b1;
        end else if (eng_req_i && (lock_q || !ld_req_i || !rr_q)) begin
            eng_gnt_s = 1'b1;
        end else if (ld_req_i && !lock_q) begin
            ld_gnt_s = 1'b1;
        end else begin
            disp_win_s = 1'b0;
        end
    end

    // RAM port mux and read-owner capture for the winner.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {AW{1'b0}};
        mem_wdata_o = 1'b0;
        owner_d     = OWN_NONE;
        if (disp_win_s) begin
            mem_en_o   = 1'b1;
            mem_addr_o = disp_addr_i;
            owner_d    = OWN_DISP;
        end else if (eng_gnt_s) begin
            mem_en_o    = 1'b1;
            mem_we_o    = eng_we_i;
            mem_addr_o  = eng_addr_i;
            mem_wdata_o = eng_wdata_i;
            owner_d     = eng_we_i ? OWN_NONE : OWN_ENG;
        end else if (ld_gnt_s) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ld_we_i;
            mem_addr_o  = ld_addr_i;
            mem_wdata_o = ld_wdata_i;
            owner_d     = ld_we_i ? OWN_NONE : OWN_LD;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Round-robin pointer and engine lock next state; the lock only releases one cycle after eng_lock drops.
    always_comb begin
        rr_d   = rr_q;
        lock_d = lock_q;
        if (eng_gnt_s) begin
            rr_d = 1'b1;
        end else if (ld_gnt_s) begin
            rr_d = 1'b0;
        end else begin
            rr_d = rr_q;
        end
        if (!eng_lock_i) begin
            lock_d = 1'b0;
        end else if (eng_gnt_s) begin
            lock_d = 1'b1;
        end else begin
            lock_d = lock_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q <= OWN_NONE;
            rr_q    <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
        end
    end

    assign eng_gnt_o     = eng_gnt_s;
    assign ld_gnt_o      = ld_gnt_s;
    assign disp_rvalid_o = !reset_i && (owner_q == OWN_DISP);
    assign eng_rvalid_o  = !reset_i && (owner_q == OWN_ENG);
    assign ld_rvalid_o   = !reset_i && (owner_q == OWN_LD);
    assign rdata_o       = (disp_rvalid_o || eng_rvalid_o || ld_rvalid_o) ? mem_rdata_i : 1'b0;

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] stall_eng_q, stall_eng_d;
    logic [CNT_W-1:0] stall_ld_q, stall_ld_d;

    // Saturating stall counters: a cycle stalls when the requester asks but is not granted.
    always_comb begin
        stall_eng_d = stall_eng_q;
        stall_ld_d  = stall_ld_q;
        if (eng_req_i && !eng_gnt_s && (stall_eng_q != {CNT_W{1'b1}})) begin
            stall_eng_d = stall_eng_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_eng_d = stall_eng_q;
        end
        if (ld_req_i && !ld_gnt_s && (stall_ld_q != {CNT_W{1'b1}})) begin
            stall_ld_d = stall_ld_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_ld_d = stall_ld_q;
        end
    end

    // Stall counter registers, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_eng_q <= {CNT_W{1'b0}};
            stall_ld_q  <= {CNT_W{1'b0}};
        end else begin
            stall_eng_q <= stall_eng_d;
            stall_ld_q  <= stall_ld_d;
        end
    end

    assign stall_eng_o = stall_eng_q;
    assign stall_ld_o  = stall_ld_q;
`endif

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: a vector table for single-cycle behaviour plus hand-written
// sequences for reset, alternation, display preemption, lock and (ARB_PERF_CNT_EN) stall counters.
module tb_board_mem_arbiter;

    localparam int AW    = 12;
    localparam int CNT_W = 16;
    localparam int NV    = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req, eng_req, eng_we, eng_wdata, eng_lock, ld_req, ld_we, ld_wdata;
    logic [AW-1:0] disp_addr, eng_addr, ld_addr;
    logic          disp_rvalid, eng_gnt, eng_rvalid, ld_gnt, ld_rvalid, rdata;
    logic          mem_en, mem_we, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rdata = 1'b0;
    logic          ram [0:(1<<AW)-1];
`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] stall_eng, stall_ld;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          dreq;
        logic [AW-1:0] daddr;
        logic          ereq, ewe;
        logic [AW-1:0] eaddr;
        logic          ewd, elock, lreq, lwe;
        logic [AW-1:0] laddr;
        logic          lwd;
        logic          x_egnt, x_lgnt, x_en, x_we;
        logic [AW-1:0] x_addr;
        logic          x_wd, x_drv, x_erv, x_lrv, x_rdata;
    } vec_t;

    vec_t vecs [NV];

    board_mem_arbiter #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .reset_i(reset),
        .disp_req_i(disp_req), .disp_addr_i(disp_addr), .disp_rvalid_o(disp_rvalid),
        .eng_req_i(eng_req), .eng_we_i(eng_we), .eng_addr_i(eng_addr), .eng_wdata_i(eng_wdata),
        .eng_lock_i(eng_lock), .eng_gnt_o(eng_gnt), .eng_rvalid_o(eng_rvalid),
        .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
        .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .rdata_o(rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .stall_eng_o(stall_eng), .stall_ld_o(stall_ld)
`endif
    );

    always #5 clk = ~clk;

    // Board RAM model: sync read, 1-cycle latency; contents reloaded while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= 1'b0;
            ram[12'h041] <= 1'b1;
            ram[12'h100] <= 1'b1;
            ram[12'h7FF] <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_req = 1'b0; disp_addr = '0;
        eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = 1'b0; eng_lock = 1'b0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        //          dreq daddr  ereq ewe eaddr  ewd elk lreq lwe laddr  lwd | egnt lgnt en  we  addr   wd  drv erv lrv rd
        vecs[0]  = '{1'b0,12'h000,1'b1,1'b0,12'h041,1'b0,1'b0,1'b0,1'b0,12'h000,1'b0, 1'b1,1'b0,1'b1,1'b0,12'h041,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,12'h000,1'b0,1'b0,12'h000,1'b0,1'b0,1'b0,1'b0,12'h000,1'b0, 1'b0,1'b0,1'b0,1'b0,12'h000,1'b0,1'b0,1'b1,1'b0,1'b1};
        vecs[2]  = '{1'b0,12'h000,1'b1,1'b0,12'h100,1'b0,1'b0,1'b1,1'b0,12'h041,1'b0, 1'b0,1'b1,1'b1,1'b0,12'h041,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,12'h000,1'b1,1'b0,12'h100,1'b0,1'b0,1'b1,1'b0,12'h002,1'b0, 1'b1,1'b0,1'b1,1'b0,12'h100,1'b0,1'b0,1'b0,1'b1,1'b1};
        vecs[4]  = '{1'b0,12'h000,1'b0,1'b0,12'h000,1'b0,1'b0,1'b1,1'b1,12'h100,1'b0, 1'b0,1'b1,1'b1,1'b1,12'h100,1'b0,1'b0,1'b1,1'b0,1'b1};
        vecs[5]  = '{1'b0,12'h000,1'b1,1'b0,12'h100,1'b0,1'b0,1'b0,1'b0,12'h000,1'b0, 1'b1,1'b0,1'b1,1'b0,12'h100,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,12'h7FF,1'b1,1'b1,12'h005,1'b1,1'b0,1'b1,1'b0,12'h005,1'b0, 1'b0,1'b0,1'b1,1'b0,12'h7FF,1'b0,1'b0,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0,12'h000,1'b1,1'b1,12'h005,1'b1,1'b0,1'b1,1'b0,12'h005,1'b0, 1'b0,1'b1,1'b1,1'b0,12'h005,1'b0,1'b1,1'b0,1'b0,1'b1};
        vecs[8]  = '{1'b0,12'h000,1'b1,1'b1,12'h005,1'b1,1'b0,1'b0,1'b0,12'h000,1'b0, 1'b1,1'b0,1'b1,1'b1,12'h005,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[9]  = '{1'b0,12'h000,1'b0,1'b0,12'h000,1'b0,1'b0,1'b1,1'b0,12'h005,1'b0, 1'b0,1'b1,1'b1,1'b0,12'h005,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,12'h000,1'b0,1'b0,12'h000,1'b0,1'b0,1'b0,1'b0,12'h000,1'b0, 1'b0,1'b0,1'b0,1'b0,12'h000,1'b0,1'b0,1'b0,1'b1,1'b1};

        // Reset held 3 cycles with every requester asking.
        idle();
        reset = 1'b1;
        disp_req = 1'b1; eng_req = 1'b1; ld_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_egnt", i), 32'(eng_gnt), 32'd0);
            chk($sformatf("rst%0d_lgnt", i), 32'(ld_gnt), 32'd0);
            chk($sformatf("rst%0d_en", i), 32'(mem_en), 32'd0);
            chk($sformatf("rst%0d_rv", i), 32'({disp_rvalid, eng_rvalid, ld_rvalid}), 32'd0);
            cyc();
        end
        reset = 1'b0;
        idle();

        // Vector table, applied straight out of reset (rr=0, no lock, no read in flight).
        for (int k = 0; k < NV; k++) begin
            disp_req = vecs[k].dreq; disp_addr = vecs[k].daddr;
            eng_req = vecs[k].ereq; eng_we = vecs[k].ewe; eng_addr = vecs[k].eaddr;
            eng_wdata = vecs[k].ewd; eng_lock = vecs[k].elock;
            ld_req = vecs[k].lreq; ld_we = vecs[k].lwe; ld_addr = vecs[k].laddr; ld_wdata = vecs[k].lwd;
            @(negedge clk);
            chk($sformatf("v%0d_egnt", k), 32'(eng_gnt), 32'(vecs[k].x_egnt));
            chk($sformatf("v%0d_lgnt", k), 32'(ld_gnt), 32'(vecs[k].x_lgnt));
            chk($sformatf("v%0d_en", k), 32'(mem_en), 32'(vecs[k].x_en));
            chk($sformatf("v%0d_we", k), 32'(mem_we), 32'(vecs[k].x_we));
            chk($sformatf("v%0d_addr", k), 32'(mem_addr), 32'(vecs[k].x_addr));
            chk($sformatf("v%0d_wd", k), 32'(mem_wdata), 32'(vecs[k].x_wd));
            chk($sformatf("v%0d_drv", k), 32'(disp_rvalid), 32'(vecs[k].x_drv));
            chk($sformatf("v%0d_erv", k), 32'(eng_rvalid), 32'(vecs[k].x_erv));
            chk($sformatf("v%0d_lrv", k), 32'(ld_rvalid), 32'(vecs[k].x_lrv));
            chk($sformatf("v%0d_rdata", k), 32'(rdata), 32'(vecs[k].x_rdata));
            cyc();
        end

        // Engine and loader both requesting: strict alternation starting with the engine.
        do_reset();
        eng_req = 1'b1; eng_addr = 12'h010; ld_req = 1'b1; ld_addr = 12'h020;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("alt%0d_egnt", i), 32'(eng_gnt), 32'(i % 2 == 0));
            chk($sformatf("alt%0d_lgnt", i), 32'(ld_gnt), 32'(i % 2 == 1));
            if (i > 0) chk($sformatf("alt%0d_erv", i), 32'(eng_rvalid), 32'(i % 2 == 1));
            cyc();
        end

        // Display holds off the engine for 5 cycles; engine wins the cycle display drops.
        do_reset();
        disp_req = 1'b1; disp_addr = 12'h7FF; eng_req = 1'b1; eng_addr = 12'h003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("disp%0d_egnt", i), 32'(eng_gnt), 32'd0);
            chk($sformatf("disp%0d_addr", i), 32'(mem_addr), 32'h7FF);
            chk($sformatf("disp%0d_drv", i), 32'(disp_rvalid), 32'(i > 0));
            cyc();
        end
        disp_req = 1'b0;
        @(negedge clk);
        chk("disp_drop_egnt", 32'(eng_gnt), 32'd1);
        chk("disp_drop_drv", 32'(disp_rvalid), 32'd1);
        chk("disp_drop_rdata", 32'(rdata), 32'd1);
        cyc();

        // Engine lock: loader shut out while locked, display still preempts, release one cycle late.
        do_reset();
        eng_req = 1'b1; eng_lock = 1'b1; eng_addr = 12'h011; ld_req = 1'b1; ld_addr = 12'h030;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("lock%0d_egnt", i), 32'(eng_gnt), 32'd1);
            chk($sformatf("lock%0d_lgnt", i), 32'(ld_gnt), 32'd0);
            cyc();
        end
        disp_req = 1'b1;
        @(negedge clk);
        chk("lock_disp_egnt", 32'(eng_gnt), 32'd0);
        chk("lock_disp_lgnt", 32'(ld_gnt), 32'd0);
        cyc();
        disp_req = 1'b0; eng_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("lockidle%0d_lgnt", i), 32'(ld_gnt), 32'd0);
            chk($sformatf("lockidle%0d_en", i), 32'(mem_en), 32'd0);
            cyc();
        end
        eng_lock = 1'b0;
        @(negedge clk);
        chk("unlock0_lgnt", 32'(ld_gnt), 32'd0);
        cyc();
        @(negedge clk);
        chk("unlock1_lgnt", 32'(ld_gnt), 32'd1);
        chk("unlock1_addr", 32'(mem_addr), 32'h030);
        cyc();

        // A read in flight when reset asserts must never return.
        do_reset();
        eng_req = 1'b1; eng_addr = 12'h041;
        @(negedge clk);
        chk("flight_egnt", 32'(eng_gnt), 32'd1);
        cyc();
        eng_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("flight_rst_erv", 32'(eng_rvalid), 32'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("flight_post_erv", 32'(eng_rvalid), 32'd0);
        cyc();

`ifdef ARB_PERF_CNT_EN
        // Loader blocked by the display for 7 cycles, then pushed far past saturation.
        do_reset();
        disp_req = 1'b1; ld_req = 1'b1;
        repeat (7) cyc();
        disp_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        chk("stall_ld_7", 32'(stall_ld), 32'd7);
        chk("stall_eng_0", 32'(stall_eng), 32'd0);
        cyc();
        disp_req = 1'b1; ld_req = 1'b1;
        repeat ((1 << CNT_W) + 3) cyc();
        @(negedge clk);
        chk("stall_ld_sat", 32'(stall_ld), 32'h0000FFFF);
        cyc();
        idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
